// File: rtl/axi_wr_sched_if.sv
// Bundle of requester-side and AXI write-port signals for axi_wr_sched.
// The master modport is the scheduler's view; slave is the surrounding system.
interface axi_wr_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 64,
  parameter int unsigned IDW  = 12
);
  localparam int unsigned IX = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*AW-1:0]     req_addr;
  logic [NREQ*8-1:0]      req_len;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_wvalid;
  logic [NREQ*DW-1:0]     req_wdata;
  logic [NREQ*DW/8-1:0]   req_wstrb;
  logic [NREQ-1:0]        req_wready;
  logic                   resp_valid;
  logic [IX-1:0]          resp_idx;
  logic [1:0]             resp_code;
  logic                   busy;
  logic                   id_err;

  logic                   m_axi_awvalid;
  logic                   m_axi_awready;
  logic [AW-1:0]          m_axi_awaddr;
  logic [7:0]             m_axi_awlen;
  logic [2:0]             m_axi_awsize;
  logic [1:0]             m_axi_awburst;
  logic [IDW-1:0]         m_axi_awid;
  logic                   m_axi_wvalid;
  logic                   m_axi_wready;
  logic [DW-1:0]          m_axi_wdata;
  logic [DW/8-1:0]        m_axi_wstrb;
  logic                   m_axi_wlast;
  logic                   m_axi_bvalid;
  logic                   m_axi_bready;
  logic [1:0]             m_axi_bresp;
  logic [IDW-1:0]         m_axi_bid;

  modport master (
    input  req_valid, req_addr, req_len, req_wvalid, req_wdata, req_wstrb,
    output req_ready, req_wready, resp_valid, resp_idx, resp_code, busy, id_err,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid,
    input  m_axi_awready,
    output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    input  m_axi_wready,
    input  m_axi_bvalid, m_axi_bresp, m_axi_bid,
    output m_axi_bready
  );

  modport slave (
    output req_valid, req_addr, req_len, req_wvalid, req_wdata, req_wstrb,
    input  req_ready, req_wready, resp_valid, resp_idx, resp_code, busy, id_err,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid,
    output m_axi_awready,
    input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
    output m_axi_wready,
    output m_axi_bvalid, m_axi_bresp, m_axi_bid,
    input  m_axi_bready
  );
endinterface

// File: rtl/axi_wr_sched.sv
// Round-robin scheduler sharing one AXI write port between NREQ requesters,
// one AW/W/B transaction at a time.
module axi_wr_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 64,
  parameter int unsigned IDW  = 12
) (
  input  logic           clk,
  input  logic           rst,
  axi_wr_sched_if.master bus
);
  localparam int unsigned IX = $clog2(NREQ);
  localparam int unsigned SW = DW / 8;
  localparam logic [2:0]  AWSIZE = 3'($clog2(SW));

  typedef enum logic [1:0] {S_IDLE, S_AWS, S_WS, S_BS} state_t;

  state_t          r_state, w_state_nxt;
  logic [IX-1:0]   r_rr_ptr, r_grant, w_grant;
  logic [IX:0]     w_cand;
  logic            w_found;
  logic [AW-1:0]   r_addr, w_sel_addr;
  logic [7:0]      r_len, w_sel_len, r_beat_cnt;
  logic            r_id_err;
  logic            w_wvalid, w_wlast, w_beat, w_bhs;
  logic [DW-1:0]   w_wdata;
  logic [SW-1:0]   w_wstrb;

  // Cyclic scan from r_rr_ptr; candidate index is folded back below NREQ.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (IX+1)'(k);
      if (w_cand >= (IX+1)'(NREQ))
        w_cand = w_cand - (IX+1)'(NREQ);
      if (!w_found && bus.req_valid[w_cand[IX-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_cand[IX-1:0];
      end
    end
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_len  = '0;
    w_wvalid   = 1'b0;
    w_wdata    = '0;
    w_wstrb    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant == IX'(i)) begin
        w_sel_addr = bus.req_addr[i*AW +: AW];
        w_sel_len  = bus.req_len[i*8 +: 8];
      end
      if (r_grant == IX'(i)) begin
        w_wvalid = bus.req_wvalid[i];
        w_wdata  = bus.req_wdata[i*DW +: DW];
        w_wstrb  = bus.req_wstrb[i*SW +: SW];
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    bus.req_ready     = '0;
    bus.req_wready    = '0;
    bus.m_axi_awvalid = 1'b0;
    bus.m_axi_wvalid  = 1'b0;
    bus.m_axi_bready  = 1'b0;
    bus.resp_valid    = 1'b0;
    bus.resp_code     = '0;
    w_wlast           = 1'b0;
    w_beat            = 1'b0;
    w_bhs             = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          bus.req_ready[w_grant] = 1'b1;
          w_state_nxt = S_AWS;
        end
      end
      S_AWS: begin
        bus.m_axi_awvalid = 1'b1;
        if (bus.m_axi_awready)
          w_state_nxt = S_WS;
      end
      S_WS: begin
        bus.m_axi_wvalid        = w_wvalid;
        w_wlast                 = (r_beat_cnt == r_len);
        bus.req_wready[r_grant] = bus.m_axi_wready;
        w_beat                  = w_wvalid && bus.m_axi_wready;
        if (w_beat && w_wlast)
          w_state_nxt = S_BS;
      end
      S_BS: begin
        bus.m_axi_bready = 1'b1;
        if (bus.m_axi_bvalid) begin
          bus.resp_valid = 1'b1;
          bus.resp_code  = bus.m_axi_bresp;
          w_bhs          = 1'b1;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_id_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_found) begin
        r_grant <= w_grant;
        r_addr  <= w_sel_addr;
        r_len   <= w_sel_len;
      end
      if (r_state == S_AWS && bus.m_axi_awready)
        r_beat_cnt <= '0;
      // Last beat leaves the count at len so a 256-beat burst never wraps.
      if (w_beat && !w_wlast)
        r_beat_cnt <= r_beat_cnt + 8'd1;
      if (w_bhs) begin
        r_rr_ptr <= (r_grant == IX'(NREQ-1)) ? '0 : r_grant + IX'(1);
        if (bus.m_axi_bid != IDW'(r_grant))
          r_id_err <= 1'b1;
      end
    end
  end

  assign bus.m_axi_awaddr  = r_addr;
  assign bus.m_axi_awlen   = r_len;
  assign bus.m_axi_awsize  = AWSIZE;
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_awid    = IDW'(r_grant);
  assign bus.m_axi_wdata   = w_wdata;
  assign bus.m_axi_wstrb   = w_wstrb;
  assign bus.m_axi_wlast   = w_wlast;
  assign bus.resp_idx      = r_grant;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.id_err        = r_id_err;
endmodule

// File: tb/tb_axi_wr_sched.sv
// Randomized bench for axi_wr_sched: plays requesters and the AXI slave and
// compares every transaction against a round-robin reference model.
module tb_axi_wr_sched;
  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int IDW  = 12;
  localparam int SW   = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_wr_sched_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) bus();

  axi_wr_sched #(.NREQ(NREQ), .AW(AW), .DW(DW), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: round-robin pointer and sticky ID error.
  int m_rr     = 0;
  bit m_id_err = 1'b0;
  logic [AW-1:0] t_addr [NREQ];
  logic [7:0]    t_len  [NREQ];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [DW-1:0] wpat(input int i, input int b);
    return {32'(i) * 32'h1001 + 32'hA5A5_0000, (32'(b) * 32'h0101_0101) ^ 32'h5A5A_5A5A};
  endfunction

  function automatic logic [SW-1:0] spat(input int i, input int b);
    return SW'(i * 29 + b * 7 + 1);
  endfunction

  task automatic idle_inputs();
    bus.req_valid     = '0;
    bus.req_addr      = '0;
    bus.req_len       = '0;
    bus.req_wvalid    = '0;
    bus.req_wdata     = '0;
    bus.req_wstrb     = '0;
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bvalid  = 1'b0;
    bus.m_axi_bresp   = '0;
    bus.m_axi_bid     = '0;
  endtask

  task automatic junk();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_wvalid[i]            = 1'($urandom);
      bus.req_wdata[i*DW +: DW]    = {$urandom, $urandom};
      bus.req_wstrb[i*SW +: SW]    = SW'($urandom);
      bus.req_addr[i*AW +: AW]     = $urandom;
      bus.req_len[i*8 +: 8]        = 8'($urandom);
    end
    bus.req_valid = NREQ'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy",    64'(bus.busy), 64'd0);
    chk("rst_awvalid", 64'(bus.m_axi_awvalid), 64'd0);
    chk("rst_wvalid",  64'(bus.m_axi_wvalid), 64'd0);
    chk("rst_wlast",   64'(bus.m_axi_wlast), 64'd0);
    chk("rst_bready",  64'(bus.m_axi_bready), 64'd0);
    chk("rst_rvalid",  64'(bus.resp_valid), 64'd0);
    chk("rst_rdy",     64'(bus.req_ready), 64'd0);
    chk("rst_wrdy",    64'(bus.req_wready), 64'd0);
    chk("rst_iderr",   64'(bus.id_err), 64'd0);
    chk("rst_awaddr",  64'(bus.m_axi_awaddr), 64'd0);
    chk("rst_awlen",   64'(bus.m_axi_awlen), 64'd0);
    chk("rst_awid",    64'(bus.m_axi_awid), 64'd0);
    chk("rst_ridx",    64'(bus.resp_idx), 64'd0);
    chk("rst_rcode",   64'(bus.resp_code), 64'd0);
    chk("rst_awsize",  64'(bus.m_axi_awsize), 64'd3);
    chk("rst_awburst", 64'(bus.m_axi_awburst), 64'd1);
    rst      = 1'b0;
    m_rr     = 0;
    m_id_err = 1'b0;
  endtask

  // wmode: 0 random W handshakes, 1 wvalid high with wready toggling, 2 both high.
  task automatic do_txn(input logic [NREQ-1:0] mask, input int stall, input int wmode,
                        input logic [1:0] bresp, input bit bad_id);
    int g, len, b, cyc, delay;
    bit wv, wr, bv, done;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx = (m_rr + k) % NREQ;
      if (g < 0 && mask[idx]) g = idx;
    end
    len = int'(t_len[g]);

    bus.req_valid = mask;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i*AW +: AW] = t_addr[i];
      bus.req_len[i*8 +: 8]    = t_len[i];
    end
    #1;
    chk("idle_busy",  64'(bus.busy), 64'd0);
    chk("req_ready",  64'(bus.req_ready), 64'd1 << g);
    chk("idle_iderr", 64'(bus.id_err), 64'(m_id_err));

    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      junk();
      bus.m_axi_awready = (cyc >= stall);
      bus.m_axi_wready  = 1'b1;
      #1;
      chk("awvalid", 64'(bus.m_axi_awvalid), 64'd1);
      chk("awaddr",  64'(bus.m_axi_awaddr), 64'(t_addr[g]));
      chk("awlen",   64'(bus.m_axi_awlen), 64'(len));
      chk("awid",    64'(bus.m_axi_awid), 64'(g));
      chk("aw_nowv", 64'(bus.m_axi_wvalid), 64'd0);
      chk("aw_rdy",  64'(bus.req_ready), 64'd0);
      done = bus.m_axi_awready;
      cyc++;
    end

    b   = 0;
    cyc = 0;
    while (b <= len && cyc < 20 * (len + 1) + 50) begin
      @(negedge clk);
      junk();
      bus.m_axi_awready = 1'b0;
      wv = (wmode == 0) ? ($urandom_range(3) != 0) : 1'b1;
      wr = (wmode == 0) ? ($urandom_range(3) != 0) : (wmode == 1) ? cyc[0] : 1'b1;
      bus.req_wvalid[g]         = wv;
      bus.req_wdata[g*DW +: DW] = wpat(g, b);
      bus.req_wstrb[g*SW +: SW] = spat(g, b);
      bus.m_axi_wready          = wr;
      #1;
      chk("wvalid", 64'(bus.m_axi_wvalid), 64'(wv));
      chk("wlast",  64'(bus.m_axi_wlast), 64'(b == len));
      chk("wready", 64'(bus.req_wready), wr ? (64'd1 << g) : 64'd0);
      if (wv) begin
        chk("wdata", 64'(bus.m_axi_wdata), 64'(wpat(g, b)));
        chk("wstrb", 64'(bus.m_axi_wstrb), 64'(spat(g, b)));
      end
      if (wv && wr) b++;
      cyc++;
    end
    if (b != len + 1) chk("w_beats", 64'(b), 64'(len + 1));

    delay = $urandom_range(3);
    for (int c = 0; c <= delay; c++) begin
      @(negedge clk);
      junk();
      bus.req_wvalid    = '1;
      bus.m_axi_wready  = 1'b1;
      bv                = (c == delay);
      bus.m_axi_bvalid  = bv;
      bus.m_axi_bresp   = bv ? bresp : 2'($urandom);
      bus.m_axi_bid     = bad_id ? (IDW'(g) ^ (IDW'(1) << (IDW - 1))) : IDW'(g);
      #1;
      chk("bready",    64'(bus.m_axi_bready), 64'd1);
      chk("b_nowv",    64'(bus.m_axi_wvalid), 64'd0);
      chk("resp_vld",  64'(bus.resp_valid), 64'(bv));
      chk("b_iderr",   64'(bus.id_err), 64'(m_id_err));
      if (bv) begin
        chk("resp_idx",  64'(bus.resp_idx), 64'(g));
        chk("resp_code", 64'(bus.resp_code), 64'(bresp));
      end
    end
    if (bad_id) m_id_err = 1'b1;
    m_rr = (g + 1) % NREQ;

    @(negedge clk);
    idle_inputs();
    #1;
    chk("post_busy",  64'(bus.busy), 64'd0);
    chk("post_rvld",  64'(bus.resp_valid), 64'd0);
    chk("post_iderr", 64'(bus.id_err), 64'(m_id_err));
  endtask

  task automatic rand_slots(input int maxlen);
    for (int i = 0; i < NREQ; i++) begin
      t_addr[i] = $urandom & 32'hFFFF_FFF8;
      t_len[i]  = 8'($urandom_range(maxlen));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_and_tests();
  end

  task automatic rst_and_tests();
    logic [NREQ-1:0] mask;

    do_reset();
    rand_slots(3);
    t_addr[1] = 32'h1000;
    t_len[1]  = 8'd3;
    do_txn(4'b0010, 0, 2, 2'b00, 1'b0);

    do_reset();
    rand_slots(4);
    for (int n = 0; n < 5; n++) do_txn('1, $urandom_range(2), 2, 2'b00, 1'b0);

    rand_slots(6);
    do_txn(4'b1001, 5, 1, 2'b00, 1'b0);

    rand_slots(5);
    t_len[m_rr] = 8'd0;
    do_txn('1, 0, 0, 2'b00, 1'b0);
    rand_slots(5);
    t_len[m_rr] = 8'd255;
    do_txn('1, 1, 0, 2'b00, 1'b0);
    rand_slots(5);
    do_txn('1, 0, 2, 2'b10, 1'b0);
    rand_slots(5);
    do_txn(4'b0100, 0, 2, 2'b00, 1'b1);
    rand_slots(5);
    do_txn(4'b0011, 0, 0, 2'b01, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rand_slots(15);
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      do_txn(mask, $urandom_range(3), $urandom_range(2), 2'($urandom),
             ($urandom_range(7) == 0));
    end

    // Reset in the middle of the W phase after two accepted beats.
    rand_slots(0);
    t_len[2] = 8'd7;
    bus.req_valid = 4'b0100;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i*AW +: AW] = t_addr[i];
      bus.req_len[i*8 +: 8]    = t_len[i];
    end
    #1;
    chk("mr_rdy", 64'(bus.req_ready), 64'd4);
    @(negedge clk);
    bus.req_valid     = '0;
    bus.m_axi_awready = 1'b1;
    #1;
    chk("mr_awv", 64'(bus.m_axi_awvalid), 64'd1);
    for (int bt = 0; bt < 2; bt++) begin
      @(negedge clk);
      bus.m_axi_awready         = 1'b0;
      bus.req_wvalid[2]         = 1'b1;
      bus.req_wdata[2*DW +: DW] = wpat(2, bt);
      bus.m_axi_wready          = 1'b1;
      #1;
      chk("mr_wv",    64'(bus.m_axi_wvalid), 64'd1);
      chk("mr_wlast", 64'(bus.m_axi_wlast), 64'd0);
    end
    @(negedge clk);
    rst              = 1'b1;
    bus.m_axi_bvalid = 1'b1;
    bus.m_axi_bid    = IDW'(2);
    @(negedge clk);
    rst      = 1'b0;
    m_rr     = 0;
    m_id_err = 1'b0;
    #1;
    chk("mr_awv0",  64'(bus.m_axi_awvalid), 64'd0);
    chk("mr_wv0",   64'(bus.m_axi_wvalid), 64'd0);
    chk("mr_br0",   64'(bus.m_axi_bready), 64'd0);
    chk("mr_busy0", 64'(bus.busy), 64'd0);
    chk("mr_rv0",   64'(bus.resp_valid), 64'd0);
    chk("mr_ie0",   64'(bus.id_err), 64'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("mr_rv_idle", 64'(bus.resp_valid), 64'd0);
    end
    idle_inputs();
    rand_slots(3);
    do_txn('1, 0, 0, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask
endmodule
